pattern_fetch_sequencer: RTL and testbench

Scanline fetch controller that feeds the 9-lane pixel shift-register block (8 sprite lanes, 1 background lane).
- During horizontal blank it fetches one 32-bit pattern row per sprite and the first background word.
- During active video it generates per-pixel shift enables and streams background words ahead of the shifter.
- It sits between the sprite evaluation stage and the pattern memory port upstream, and the shift-register block downstream.

---
 rtl/pattern_fetch_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_pattern_fetch_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_fetch_sequencer.sv
// Scanline fetch controller: fetches sprite pattern rows during hblank, then streams
// background words and per-pixel shift enables to the 9-lane shifter during active video.
module pattern_fetch_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int LINE_PIXELS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic                  pixel_tick,
    input  logic [7:0]            sprite_valid,
    input  logic [8*9-1:0]        sprite_x,
    input  logic [8*ADDR_W-1:0]   sprite_row_addr,
    input  logic [ADDR_W-1:0]     bg_base_addr,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic [9*32-1:0]       load_data,
    output logic                  load_sprite,
    output logic                  load_background,
    output logic [8:0]            enable,
    output logic                  busy,
    output logic                  line_done,
    output logic                  underrun
);

    localparam logic [5:0] WORDS  = 6'(LINE_PIXELS / 16);
    localparam logic [8:0] LAST_X = 9'(LINE_PIXELS - 1);

    typedef enum logic [2:0] {IDLE, SPR_FETCH, SPR_LOAD, BG_FIRST, ACTIVE} state_t;

    state_t                state;
    logic [2:0]            spr_idx;
    logic [7:0]            valid_q;
    logic [8*9-1:0]        x_q;
    logic [8*ADDR_W-1:0]   row_q;
    logic [ADDR_W-1:0]     bg_q;
    logic [8:0]            pixel_x;
    logic [7:0][4:0]       shifts;
    logic [5:0]            word_k;
    logic                  need;
    logic                  pending;
    logic                  discard;

    logic ack_ok;
    logic tick;
    logic last_tick;
    logic reload;
    logic will_issue;

    assign ack_ok     = mem_req && mem_ack;
    assign tick       = (state == ACTIVE) && pixel_tick;
    assign last_tick  = tick && (pixel_x == LAST_X);
    assign reload     = tick && (pixel_x[3:0] == 4'hF) && !last_tick;
    assign will_issue = need && !mem_req;
    assign busy       = (state != IDLE);

    always_comb begin
        enable    = '0;
        enable[8] = tick;
        for (int i = 0; i < 8; i++) begin
            enable[i] = tick && valid_q[i] && (pixel_x >= x_q[9*i +: 9]) && (shifts[i] < 5'd16);
        end
    end

    // word_k is the index of the background word currently being fetched (or next to fetch);
    // discard marks an outstanding request whose data must be dropped when it finally acks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            spr_idx         <= '0;
            valid_q         <= '0;
            x_q             <= '0;
            row_q           <= '0;
            bg_q            <= '0;
            pixel_x         <= '0;
            shifts          <= '0;
            word_k          <= '0;
            need            <= 1'b0;
            pending         <= 1'b0;
            discard         <= 1'b0;
            mem_req         <= 1'b0;
            mem_addr        <= '0;
            load_data       <= '0;
            load_sprite     <= 1'b0;
            load_background <= 1'b0;
            line_done       <= 1'b0;
            underrun        <= 1'b0;
        end else begin
            load_sprite     <= 1'b0;
            load_background <= 1'b0;
            line_done       <= 1'b0;

            if (ack_ok) begin
                mem_req <= 1'b0;
                discard <= 1'b0;
            end

            for (int i = 0; i < 8; i++) begin
                if (enable[i]) shifts[i] <= shifts[i] + 5'd1;
            end

            case (state)
                IDLE: begin
                    if (line_start) begin
                        valid_q  <= sprite_valid;
                        x_q      <= sprite_x;
                        row_q    <= sprite_row_addr;
                        bg_q     <= bg_base_addr;
                        underrun <= 1'b0;
                        spr_idx  <= '0;
                        pixel_x  <= '0;
                        shifts   <= '0;
                        word_k   <= '0;
                        need     <= 1'b0;
                        pending  <= 1'b0;
                        state    <= SPR_FETCH;
                    end
                end

                SPR_FETCH: begin
                    if (!valid_q[spr_idx] || (ack_ok && !discard)) begin
                        load_data[32*int'(spr_idx) +: 32] <= valid_q[spr_idx] ? mem_rdata : 32'h0;
                        if (spr_idx == 3'd7) begin
                            load_sprite <= 1'b1;
                            state       <= SPR_LOAD;
                        end else begin
                            spr_idx <= spr_idx + 3'd1;
                        end
                    end else if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= row_q[ADDR_W*int'(spr_idx) +: ADDR_W];
                    end
                end

                SPR_LOAD: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= bg_q;
                        state    <= BG_FIRST;
                    end
                end

                BG_FIRST: begin
                    if (ack_ok && !discard) begin
                        load_data[8*32 +: 32] <= mem_rdata;
                        load_background       <= 1'b1;
                        word_k                <= 6'd1;
                        need                  <= (6'd1 < WORDS);
                        state                 <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (pixel_tick) pixel_x <= pixel_x + 9'd1;

                    if (ack_ok && !discard) begin
                        load_data[8*32 +: 32] <= mem_rdata;
                        pending               <= 1'b1;
                        word_k                <= word_k + 6'd1;
                    end

                    if (will_issue) begin
                        mem_req  <= 1'b1;
                        mem_addr <= bg_q + ADDR_W'(word_k);
                        need     <= 1'b0;
                    end

                    // A late word is skipped: the shifter gets zeros and whatever request is
                    // in flight for it is left to complete and then thrown away.
                    if (reload) begin
                        load_background <= 1'b1;
                        if (pending) begin
                            pending <= 1'b0;
                            need    <= (word_k < WORDS);
                        end else begin
                            load_data[8*32 +: 32] <= 32'h0;
                            underrun              <= 1'b1;
                            pending               <= 1'b0;
                            word_k                <= word_k + 6'd1;
                            need                  <= ((word_k + 6'd1) < WORDS);
                            discard               <= (mem_req && !mem_ack) || will_issue;
                        end
                    end

                    if (last_tick) begin
                        line_done <= 1'b1;
                        need      <= 1'b0;
                        pending   <= 1'b0;
                        discard   <= (mem_req && !mem_ack) || will_issue;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_fetch_sequencer.sv
// Directed bench for pattern_fetch_sequencer: sprite fetch, background streaming,
// underrun, mid-transfer reset and ignored line_start, with a latency-programmable memory model.
module tb_pattern_fetch_sequencer;

    logic          clk;
    logic          reset;
    logic          line_start;
    logic          pixel_tick;
    logic [7:0]    sprite_valid;
    logic [71:0]   sprite_x;
    logic [127:0]  sprite_row_addr;
    logic [15:0]   bg_base_addr;
    logic          mem_req;
    logic [15:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic [287:0]  load_data;
    logic          load_sprite;
    logic          load_background;
    logic [8:0]    enable;
    logic          busy;
    logic          line_done;
    logic          underrun;

    pattern_fetch_sequencer #(.ADDR_W(16), .LINE_PIXELS(256)) dut (
        .clk             (clk),
        .reset           (reset),
        .line_start      (line_start),
        .pixel_tick      (pixel_tick),
        .sprite_valid    (sprite_valid),
        .sprite_x        (sprite_x),
        .sprite_row_addr (sprite_row_addr),
        .bg_base_addr    (bg_base_addr),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .load_data       (load_data),
        .load_sprite     (load_sprite),
        .load_background (load_background),
        .enable          (enable),
        .busy            (busy),
        .line_done       (line_done),
        .underrun        (underrun)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;

    bit        resp_en = 1'b1;
    int        spr_lat = 3;
    int        bg_lat  = 2;
    logic [15:0] slow_addr = 16'hFFFF;

    logic [15:0] req_log[$];
    logic        req_prev = 1'b0;
    int          ls_count, lb_count, e0, e8, esum, ld_count, e0_first, ls_cyc;
    logic [287:0] ls_data;
    logic [31:0]  lb_data [32];
    logic         ud_at_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int latFor(input logic [15:0] a);
        if (a == slow_addr) return 40;
        if (a[15:8] == 8'h01) return spr_lat;
        return bg_lat;
    endfunction

    function automatic logic [31:0] rdataFor(input logic [15:0] a);
        if (a[15:8] == 8'h01) return 32'hA000_0000 + 32'(a[7:0]);
        return 32'hB000_0000 + 32'(a);
    endfunction

    // Memory model: acks after latFor() cycles of held request, one-cycle ack pulse.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    cnt = 0;
                end else if (mem_req) begin
                    cnt++;
                    if (cnt >= latFor(mem_addr)) begin
                        mem_ack = 1'b1;
                        mem_rdata = rdataFor(mem_addr);
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            req_prev = 1'b0;
        end else begin
            if (mem_req && !req_prev) req_log.push_back(mem_addr);
            req_prev = mem_req;
            if (load_sprite) begin
                ls_count++;
                ls_data = load_data;
                ls_cyc = cyc;
            end
            if (load_background) begin
                if (lb_count < 32) lb_data[lb_count] = load_data[287:256];
                lb_count++;
            end
            if (enable[0] && e0 == 0) e0_first = e8;
            if (enable[0]) e0++;
            if (enable[8]) e8++;
            for (int i = 0; i < 8; i++) if (enable[i]) esum++;
            if (line_done) begin
                ld_count++;
                ud_at_done = underrun;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearLogs();
        req_log.delete();
        ls_count = 0; lb_count = 0; e0 = 0; e8 = 0; esum = 0; ld_count = 0;
        e0_first = -1; ls_cyc = 0; ud_at_done = 1'b0;
        for (int i = 0; i < 32; i++) lb_data[i] = '0;
    endtask

    task automatic applyStimulus(input logic [7:0] valid, input logic [15:0] bg);
        sprite_valid = valid;
        bg_base_addr = bg;
        @(posedge clk);
        #1 line_start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1 line_start = 1'b0;
    endtask

    task automatic waitLoadSprite(input int budget);
        int t = 0;
        while (ls_count < 1 && t < budget) begin @(posedge clk); t++; end
    endtask

    task automatic waitLoadBackground(input int budget);
        int t = 0;
        while (lb_count < 1 && t < budget) begin @(posedge clk); t++; end
    endtask

    task automatic waitLineDone(input int budget);
        int t = 0;
        while (ld_count < 1 && t < budget) begin @(posedge clk); t++; end
    endtask

    // Ticks every other cycle; a stray line_start with a different bg base can be injected.
    task automatic runTicks(input int count, input int spur);
        for (int n = 0; n < count; n++) begin
            @(posedge clk);
            #1 pixel_tick = 1'b1;
            line_start = 1'b0;
            if (n == spur + 1) checkOutput("busy_after_spurious", busy, 1);
            @(posedge clk);
            #1 pixel_tick = 1'b0;
            if (n == spur) begin
                line_start   = 1'b1;
                bg_base_addr = 16'h3000;
            end
        end
        line_start = 1'b0;
        bg_base_addr = 16'h2000;
    endtask

    initial begin
        reset = 1'b0;
        line_start = 1'b0;
        pixel_tick = 1'b0;
        sprite_valid = '0;
        bg_base_addr = '0;
        for (int i = 0; i < 8; i++) begin
            sprite_x[9*i +: 9] = 9'(10 + 30*i);
            sprite_row_addr[16*i +: 16] = 16'h0100 + 16'(i);
        end
        clearLogs();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_load_data_zero", load_data == '0, 1);
        checkOutput("rst_enable", enable, 0);
        checkOutput("rst_pulses", {line_done, load_sprite, load_background, underrun}, 0);
        reset = 1'b1;

        $display("[TB] all sprites valid, full line, stray line_start mid-line");
        clearLogs();
        applyStimulus(8'hFF, 16'h2000);
        waitLoadSprite(200);
        checkOutput("a_ls_count", ls_count, 1);
        checkOutput("a_fetch_cycles", ls_cyc - start_cyc, 33);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("a_spr_addr%0d", i), (req_log.size() > i) ? req_log[i] : 16'hDEAD, 16'h0100 + 16'(i));
            checkOutput($sformatf("a_lane%0d", i), ls_data[32*i +: 32], 32'hA000_0000 + 32'(i));
        end
        waitLoadBackground(50);
        checkOutput("a_first_bg", lb_count, 1);
        checkOutput("a_bg_addr0", (req_log.size() > 8) ? req_log[8] : 16'hDEAD, 16'h2000);
        runTicks(256, 100);
        waitLineDone(20);
        checkOutput("a_line_done", ld_count, 1);
        checkOutput("a_enable8", e8, 256);
        checkOutput("a_enable0", e0, 16);
        checkOutput("a_enable0_first_x", e0_first, 10);
        checkOutput("a_sprite_enables", esum, 128);
        checkOutput("a_bg_loads", lb_count, 16);
        checkOutput("a_req_total", req_log.size(), 24);
        for (int k = 0; k < 16; k++)
            checkOutput($sformatf("a_bg_addr%0d", k), (req_log.size() > 8 + k) ? req_log[8+k] : 16'hDEAD, 16'h2000 + 16'(k));
        checkOutput("a_bg_word0", lb_data[0], 32'hB000_2000);
        checkOutput("a_bg_word15", lb_data[15], 32'hB000_200F);
        checkOutput("a_busy_end", busy, 0);
        checkOutput("a_underrun", underrun, 0);

        $display("[TB] sparse sprites, late background word 2");
        clearLogs();
        slow_addr = 16'h2002;
        applyStimulus(8'b0000_0101, 16'h2000);
        waitLoadSprite(200);
        checkOutput("b_fetch_cycles", ls_cyc - start_cyc, 15);
        checkOutput("b_spr_reqs", req_log.size(), 2);
        checkOutput("b_spr_addr0", (req_log.size() > 0) ? req_log[0] : 16'hDEAD, 16'h0100);
        checkOutput("b_spr_addr1", (req_log.size() > 1) ? req_log[1] : 16'hDEAD, 16'h0102);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("b_lane%0d", i), ls_data[32*i +: 32], (i == 0 || i == 2) ? 32'hA000_0000 + 32'(i) : 32'h0);
        waitLoadBackground(50);
        runTicks(256, -5);
        waitLineDone(20);
        checkOutput("b_line_done", ld_count, 1);
        checkOutput("b_bg_loads", lb_count, 16);
        checkOutput("b_word1", lb_data[1], 32'hB000_2001);
        checkOutput("b_word2_zero", lb_data[2], 32'h0);
        checkOutput("b_word3", lb_data[3], 32'hB000_2003);
        checkOutput("b_underrun_at_done", ud_at_done, 1);
        checkOutput("b_underrun_after", underrun, 1);
        checkOutput("b_sprite_enables", esum, 32);
        checkOutput("b_req_total", req_log.size(), 18);
        checkOutput("b_last_addr", (req_log.size() > 0) ? req_log[req_log.size()-1] : 16'hDEAD, 16'h200F);
        slow_addr = 16'hFFFF;

        $display("[TB] reset during sprite fetch, late ack, clean refetch");
        clearLogs();
        spr_lat = 50;
        applyStimulus(8'hFF, 16'h2000);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("c_underrun_cleared", underrun, 0);
        checkOutput("c_req_pending", mem_req, 1);
        checkOutput("c_busy", busy, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checkOutput("c_async_req", mem_req, 0);
        checkOutput("c_async_busy", busy, 0);
        checkOutput("c_async_addr", mem_addr, 0);
        checkOutput("c_async_data", load_data == '0, 1);
        resp_en = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("c_late_ack_req", mem_req, 0);
        checkOutput("c_late_ack_busy", busy, 0);
        checkOutput("c_late_ack_data", load_data == '0, 1);
        resp_en = 1'b1;
        spr_lat = 3;
        clearLogs();
        applyStimulus(8'hFF, 16'h2000);
        waitLoadSprite(200);
        checkOutput("c_refetch_cycles", ls_cyc - start_cyc, 33);
        checkOutput("c_refetch_reqs", req_log.size(), 8);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("c_refetch_addr%0d", i), (req_log.size() > i) ? req_log[i] : 16'hDEAD, 16'h0100 + 16'(i));
        checkOutput("c_refetch_lane5", ls_data[5*32 +: 32], 32'hA000_0005);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
